// File: rtl/cgra_io_sched_ctrl.sv
// rtl/cgra_io_sched_ctrl.sv - run controller and schedule-driven load/store feeder for the PE array
// Two data banks feed the array load ports while a prefetched address schedule steers loads and stores.
module cgra_io_sched_ctrl #(
  parameter int DWIDTH = 32,
  parameter int DAW    = 8,
  parameter int SAW    = 8
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic [SAW:0]      Cycle_Num,
  output logic              Done,
  output logic              Busy,
  input  logic              Host_We,
  input  logic              Host_Bank,
  input  logic [DAW-1:0]    Host_Addr,
  input  logic [DWIDTH-1:0] Host_WData,
  output logic [DWIDTH-1:0] Host_RData,
  input  logic              Sched_We,
  input  logic [SAW-1:0]    Sched_Addr,
  input  logic [4*DAW+1:0]  Sched_WData,
  output logic              Host_Err,
  output logic [DWIDTH-1:0] Data0_Load,
  output logic [DWIDTH-1:0] Data1_Load,
  input  logic [DWIDTH-1:0] Data0_Store,
  input  logic [DWIDTH-1:0] Data1_Store,
  output logic              PE_Array_Busy
);

  localparam logic [SAW:0] N_MAX = {1'b1, {SAW{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FILL1, S_FILL2, S_RUN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [DWIDTH-1:0]  bank0     [2**DAW];
  logic [DWIDTH-1:0]  bank1     [2**DAW];
  logic [4*DAW+1:0]   sched_mem [2**SAW];

  logic [4*DAW+1:0]   sched_q;
  logic [2*DAW+1:0]   wr_q;
  logic [SAW:0]       n_lat, cnt;
  logic [SAW-1:0]     fetch_cnt;
  logic [DWIDTH-1:0]  load0_q, load1_q, rdata_q;
  logic               err_q;

  logic [DAW-1:0]     rd0_addr, rd1_addr, wr0_addr, wr1_addr;
  logic               wr0_en, wr1_en, idle, run;

  // sched_q holds entry c+1 during RUN cycle c; wr_q is one stage later, so it holds entry c
  assign rd0_addr = sched_q[DAW-1:0];
  assign rd1_addr = sched_q[3*DAW:2*DAW+1];
  assign wr0_addr = wr_q[DAW-1:0];
  assign wr0_en   = wr_q[DAW];
  assign wr1_addr = wr_q[2*DAW:DAW+1];
  assign wr1_en   = wr_q[2*DAW+1];

  assign idle          = (state == S_IDLE);
  assign run           = (state == S_RUN);
  assign Busy          = !idle;
  assign Done          = (state == S_DONE);
  assign PE_Array_Busy = run;
  assign Data0_Load    = run ? load0_q : '0;
  assign Data1_Load    = run ? load1_q : '0;
  assign Host_RData    = rdata_q;
  assign Host_Err      = err_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (Start) state_nxt = (Cycle_Num == '0) ? S_DONE : S_FILL1;
      S_FILL1: state_nxt = S_FILL2;
      S_FILL2: state_nxt = S_RUN;
      S_RUN:   if (cnt == n_lat - 1'b1) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      n_lat     <= '0;
      cnt       <= '0;
      fetch_cnt <= '0;
      sched_q   <= '0;
      wr_q      <= '0;
      load0_q   <= '0;
      load1_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_nxt;
      err_q   <= !idle && (Host_We || Sched_We);
      sched_q <= sched_mem[fetch_cnt];
      wr_q    <= {sched_q[4*DAW+1:3*DAW+1], sched_q[2*DAW:DAW]};
      load0_q <= bank0[rd0_addr];
      load1_q <= bank1[rd1_addr];
      if (idle) begin
        fetch_cnt <= '0;
        cnt       <= '0;
        if (Start && Cycle_Num != '0)
          n_lat <= (Cycle_Num > N_MAX) ? N_MAX : Cycle_Num;
        if (!Host_We)
          rdata_q <= Host_Bank ? bank1[Host_Addr] : bank0[Host_Addr];
      end else begin
        // prefetch runs ahead past N-1; those entries are never stored
        fetch_cnt <= fetch_cnt + 1'b1;
      end
      if (run)
        cnt <= cnt + 1'b1;
    end
  end

  // Memories are never reset; host and array writes are separated by state
  always_ff @(posedge Clk) begin
    if (idle && Host_We && !Host_Bank)
      bank0[Host_Addr] <= Host_WData;
    else if (run && wr0_en)
      bank0[wr0_addr] <= Data0_Store;
    if (idle && Host_We && Host_Bank)
      bank1[Host_Addr] <= Host_WData;
    else if (run && wr1_en)
      bank1[wr1_addr] <= Data1_Store;
    if (idle && Sched_We)
      sched_mem[Sched_Addr] <= Sched_WData;
  end

endmodule
